// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and instruction field positions for the fetch stage
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

    localparam int INSTR_W   = 32;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int TGT_MSB   = 25;
    localparam int TGT_LSB   = 0;

    // Branch displacement in bytes: sign-extended word offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection: jump, taken branch or sequential
module next_pc_calc
    import mips_fetch_pkg::*;
(
    input  logic [31:0]        pc_plus4,
    input  logic [INSTR_W-1:0] instr,
    input  logic               pcsrc,
    input  logic               jump,
    output logic [31:0]        next_pc
);

    logic unused_op_funct;
    assign unused_op_funct = ^instr[OP_MSB:OP_LSB];

    // Jump takes priority over a taken branch; all sums wrap modulo 2^32.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[TGT_MSB:TGT_LSB], 2'b00};
        end else if (pcsrc) begin
            next_pc = pc_plus4 + branch_offset(instr[IMM_MSB:IMM_LSB]);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, imem handshake, held instruction
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               commit,
    input  logic               pcsrc,
    input  logic               jump,
    output logic               fetch_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    fetch_state_t     state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    next_pc_calc u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .pcsrc    (pcsrc),
        .jump     (jump),
        .next_pc  (next_pc)
    );

    // MAX_WAIT consecutive not-ready REQ cycles end in the sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        wait_cnt    <= '0;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= VALID;
                    end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                VALID: begin
                    if (commit) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        commit;
    logic        pcsrc;
    logic        jump;

    logic        imem_req,   h_imem_req;
    logic [31:0] imem_addr,  h_imem_addr;
    logic [31:0] instr,      h_instr;
    logic        instr_valid, h_instr_valid;
    logic [31:0] pc,         h_pc;
    logic [31:0] pc_plus4,   h_pc_plus4;
    logic        fetch_err,  h_fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .commit      (commit),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .fetch_err   (fetch_err)
    );

    fetch_unit #(.RESET_PC(32'h4000_0100), .MAX_WAIT(16)) u_dut_hi (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (h_imem_req),
        .imem_addr   (h_imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (h_instr),
        .instr_valid (h_instr_valid),
        .pc          (h_pc),
        .pc_plus4    (h_pc_plus4),
        .commit      (commit),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .fetch_err   (h_fetch_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr);
        check_eq({tag, ".req"},   imem_req,    32'd1);
        check_eq({tag, ".addr"},  imem_addr,   addr);
        check_eq({tag, ".valid"}, instr_valid, 32'd0);
    endtask

    task automatic chk_valid(input string tag, input logic [31:0] pc_exp, input logic [31:0] instr_exp);
        check_eq({tag, ".valid"}, instr_valid, 32'd1);
        check_eq({tag, ".req"},   imem_req,    32'd0);
        check_eq({tag, ".pc"},    pc,          pc_exp);
        check_eq({tag, ".instr"}, instr,       instr_exp);
    endtask

    task automatic commit_one(input logic j, input logic p, input logic rdy);
        commit     = 1'b1;
        jump       = j;
        pcsrc      = p;
        imem_ready = rdy;
        tick();
        commit = 1'b0;
        jump   = 1'b0;
        pcsrc  = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        imem_ready = 1'b1;
        commit     = 1'b0;
        pcsrc      = 1'b0;
        jump       = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();

        check_eq("rst.req",   imem_req,    32'd0);
        check_eq("rst.valid", instr_valid, 32'd0);
        check_eq("rst.err",   fetch_err,   32'd0);
        check_eq("rst.pc",    pc,          32'h0);
        check_eq("rst.instr", instr,       32'h0);
        check_eq("rst.hi_pc", h_pc,        32'h4000_0100);

        // Release: one IDLE cycle, then REQ, then VALID with zero-wait memory.
        reset      = 1'b0;
        imem_rdata = 32'h0800_0004;
        check_eq("idle.req", imem_req, 32'd0);
        tick();
        chk_req("boot", 32'h0);
        tick();
        chk_valid("boot", 32'h0, 32'h0800_0004);
        check_eq("boot.pc4", pc_plus4, 32'h4);

        imem_rdata = 32'h2108_0001;
        commit_one(1'b1, 1'b0, 1'b1);
        chk_req("jmp10", 32'h10);
        tick();
        chk_valid("at10", 32'h10, 32'h2108_0001);

        imem_rdata = 32'h1000_0002;
        commit_one(1'b0, 1'b0, 1'b1);
        chk_req("seq", 32'h14);
        tick();
        chk_valid("at14", 32'h14, 32'h1000_0002);

        imem_rdata = 32'h1000_FFFE;
        commit_one(1'b0, 1'b1, 1'b1);
        chk_req("br_fwd", 32'h20);
        tick();
        chk_valid("at20", 32'h20, 32'h1000_FFFE);

        commit_one(1'b0, 1'b1, 1'b1);
        chk_req("br_back", 32'h1C);
        tick();
        chk_valid("at1c", 32'h1C, 32'h1000_FFFE);
        commit_one(1'b0, 1'b0, 1'b1);
        chk_req("seq1c", 32'h20);
        tick();
        commit_one(1'b0, 1'b0, 1'b1);
        chk_req("br_nt", 32'h24);
        tick();
        chk_valid("at24", 32'h24, 32'h1000_FFFE);

        // Three wait states; a stray commit during REQ must be ignored.
        imem_rdata = 32'h1000_FFF4;
        commit_one(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_req("wait3", 32'h28);
            commit = (i < 2);
            jump   = (i < 2);
            pcsrc  = (i < 2);
            if (i == 3) imem_ready = 1'b1;
            tick();
        end
        chk_valid("wait3", 32'h28, 32'h1000_FFF4);

        imem_rdata = 32'h1234_5678;
        tick();
        tick();
        chk_valid("hold", 32'h28, 32'h1000_FFF4);

        imem_rdata = 32'h0000_0020;
        commit_one(1'b0, 1'b1, 1'b1);
        chk_req("to_top", 32'hFFFF_FFFC);
        tick();
        chk_valid("top", 32'hFFFF_FFFC, 32'h0000_0020);
        check_eq("top.pc4", pc_plus4, 32'h0);

        // Wrap, then MAX_WAIT-1 not-ready cycles is still tolerated.
        imem_rdata = 32'h0800_0010;
        commit_one(1'b0, 1'b0, 1'b0);
        chk_req("wrap", 32'h0);
        repeat (15) tick();
        check_eq("w15.req", imem_req,  32'd1);
        check_eq("w15.err", fetch_err, 32'd0);
        imem_ready = 1'b1;
        tick();
        chk_valid("w15", 32'h0, 32'h0800_0010);
        check_eq("w15.err2", fetch_err, 32'd0);

        // MAX_WAIT not-ready cycles: sticky error.
        commit_one(1'b0, 1'b0, 1'b0);
        repeat (15) tick();
        check_eq("w16a.err", fetch_err, 32'd0);
        check_eq("w16a.req", imem_req,  32'd1);
        tick();
        check_eq("to.err",   fetch_err,   32'd1);
        check_eq("to.req",   imem_req,    32'd0);
        check_eq("to.valid", instr_valid, 32'd0);
        imem_ready = 1'b1;
        commit     = 1'b1;
        tick();
        tick();
        commit = 1'b0;
        check_eq("sticky.err",   fetch_err,   32'd1);
        check_eq("sticky.req",   imem_req,    32'd0);
        check_eq("sticky.valid", instr_valid, 32'd0);

        // Jump wins over pcsrc, including the top PC nibble.
        reset = 1'b1;
        tick();
        check_eq("rst2.err", fetch_err, 32'd0);
        reset      = 1'b0;
        imem_rdata = 32'h0800_0040;
        tick();
        tick();
        chk_valid("jprio", 32'h0, 32'h0800_0040);
        check_eq("hi.valid", h_instr_valid, 32'd1);
        check_eq("hi.pc",    h_pc,          32'h4000_0100);
        commit_one(1'b1, 1'b1, 1'b0);
        chk_req("jprio", 32'h100);
        check_eq("hi.req",  h_imem_req,  32'd1);
        check_eq("hi.addr", h_imem_addr, 32'h4000_0100);
        tick();

        // Reset mid-fetch abandons the request.
        reset = 1'b1;
        tick();
        check_eq("rstreq.req",   imem_req,    32'd0);
        check_eq("rstreq.valid", instr_valid, 32'd0);
        check_eq("rstreq.pc",    pc,          32'h0);
        check_eq("rstreq.hreq",  h_imem_req,  32'd0);
        check_eq("rstreq.hpc",   h_pc,        32'h4000_0100);
        imem_ready = 1'b1;
        tick();
        check_eq("rsthold.valid", instr_valid, 32'd0);
        check_eq("rsthold.instr", instr,       32'h0);
        reset = 1'b0;
        tick();
        chk_req("reboot", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the MIPS core; sits directly upstream of the main controller/datapath.
- Owns the PC register and drives requests to a variable-latency instruction memory.
- Presents one instruction at a time to the core and holds it stable until the core commits it.
- On commit, computes the next PC from the controller's pcsrc/jump decisions: sequential, branch or jump.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (word-aligned).
- MAX_WAIT, 16, imem wait cycles tolerated before a fetch error.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held high until imem_ready.
- imem_addr  out  32  byte address of fetch, equal to pc; bits [1:0] always 0.
- imem_ready  in  1  imem_rdata valid this cycle; may be high in the same cycle as imem_req.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  held instruction; op = instr[31:26], funct = instr[5:0] feed the controller.
- instr_valid  out  1  instr and pc are valid for execution.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- commit  in  1  core finished the held instruction; advance.
- pcsrc  in  1  branch taken, from the controller; sampled only with commit.
- jump  in  1  jump, from the controller; sampled only with commit.
- fetch_err  out  1  sticky imem timeout flag.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, wait_cnt=0.
- Reset mid-fetch abandons the outstanding request; the next cycle has imem_req=0.
- States: IDLE, REQ, VALID, ERR.
- IDLE → REQ unconditionally. Exactly one IDLE cycle follows reset release.
- REQ: imem_req=1, imem_addr=pc.
  - imem_ready=1: latch imem_rdata into instr, clear wait_cnt, → VALID. Zero-wait fetch gives 1 cycle from REQ entry to instr_valid.
  - imem_ready=0: wait_cnt++.
  - wait_cnt reaching MAX_WAIT with imem_ready=0: → ERR.
- VALID: instr_valid=1; instr and pc held stable; imem_req=0.
  - commit=1: pc ← next_pc, → REQ.
- ERR: imem_req=0, instr_valid=0, fetch_err=1. Stays in ERR until reset.
- next_pc:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. jump has priority over pcsrc.
  - else pcsrc=1: pc_plus4 + (sign_extend(instr[15:0]) << 2).
  - else: pc_plus4.
  - All sums are 32-bit and wrap modulo 2^32; no overflow flag.
- commit is ignored outside VALID, so pcsrc/jump are don't-care there.
- imem_ready is ignored outside REQ; stray ready pulses do not change instr.
- imem_rdata is sampled only in a REQ cycle with imem_ready=1.
- Outputs instr, pc, instr_valid, fetch_err are registered or decoded from registered state only; no combinational path from commit/pcsrc/jump to any output.

Decomposition:
- Shared package mips_fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, VALID, ERR};
  - INSTR_W=32;
  - field position constants for op, funct, imm16, target26.
- One combinational sub-module next_pc_calc: inputs pc_plus4, instr, pcsrc, jump; output next_pc. It is reused later by the pipelined variant.

Test Plan:
- Reset release, imem_ready tied 1 → one IDLE cycle, then imem_req=1 with imem_addr=0; instr_valid=1 the following cycle with pc=0, pc_plus4=4.
- Sequential commit at pc=0x0000_0010, pcsrc=0, jump=0 → next imem_addr=0x0000_0014.
- Taken branch: pc=0x0000_0020, instr[15:0]=16'hFFFE, pcsrc=1 → imem_addr=0x0000_001C. Same instruction with pcsrc=0 → 0x0000_0024.
- Jump: pc=0x4000_0100, instr[25:0]=26'h000_0040, jump=1, pcsrc=1 → imem_addr=0x4000_0100 (jump wins over pcsrc).
- Wait states: imem_ready low 3 cycles → imem_req and imem_addr stable 4 cycles; instr_valid stays 0 until the cycle after ready. Ready low MAX_WAIT cycles → fetch_err=1, imem_req=0, held until reset.
- Wrap and reset: pc=0xFFFF_FFFC sequential commit → imem_addr=0x0000_0000. Reset asserted while in REQ → imem_req=0 next cycle, pc=RESET_PC, no stale instr_valid.
